secded_correct_pipe: RTL
========================

// Module: secded_correct_pipe
// PURPOSE
//  Parametrised SECDED (extended Hamming) decode/correct pipeline. Next generation of the
//  syndrome->mask generator: computes syndrome and overall parity from a received codeword,
//  builds the flip mask, corrects single errors, flags double errors and keeps CE/UE counts.
//  Sits on the memory read-return path between the SRAM codeword output and the data consumer.
// PARAMETERS
//  DATA_W    64  data bits per word (>=4)
//  CNT_W     16  width of saturating error counters
//  Derived (localparam, not overridable): HAM_W = smallest r with 2**r >= DATA_W+r+1
//  (7 for 64); CW_W = DATA_W+HAM_W+1 (72 for 64)
// PORTS
//  i_clk         in   1       clock, all state on rising edge
//  i_rst_n       in   1       async reset, active-low
//  i_valid       in   1       input codeword valid
//  o_ready       out  1       block can accept a codeword this cycle
//  i_codeword    in   CW_W    bit 0 = overall parity; bit k (1..CW_W-1) = Hamming position k;
//                             check bits at power-of-two positions, data LSB-first in the rest
//  i_correct_en  in   1       1: apply correction mask; 0: detect only, data passes unmodified
//  o_valid       out  1       output word valid
//  i_ready       in   1       downstream accepts output
//  o_data        out  DATA_W  (corrected) data
//  o_syndrome    out  HAM_W   Hamming syndrome of this word
//  o_err_single  out  1       correctable error detected (qualified by o_valid)
//  o_err_double  out  1       uncorrectable error detected (qualified by o_valid)
//  i_cnt_clr     in   1       synchronous clear of both counters
//  o_ce_cnt      out  CNT_W   corrected-error count, saturating
//  o_ue_cnt      out  CNT_W   uncorrectable-error count, saturating
// BEHAVIOUR
//  - Reset: o_valid=0, o_data=0, o_syndrome=0, o_err_*=0, o_ce_cnt=0, o_ue_cnt=0, stages empty.
//  - Two register stages. S1: capture codeword, i_correct_en, syndrome S (XOR of indices of set
//    bits 1..CW_W-1), overall parity P (XOR of all CW_W bits). S2: mask, correct, extract
//    data, classify. Latency: input handshake in cycle N -> o_valid in cycle N+2 if i_ready held 1.
//  - Handshake: transfer when valid&&ready on each side. Stage advances when next stage is empty
//    or being emptied this cycle. o_ready = !s1_valid || s1 advancing (combinational from
//    i_ready; no bubbles at full throughput: 1 word/cycle). Outputs held stable while
//    o_valid && !i_ready. No word dropped or duplicated under any i_ready pattern.
//  - Classification (S,P): (0,0) clean; (0,1) single, error in bit 0, data unchanged;
//    (S!=0, P=1, S<=CW_W-1) single, flip position S; (S!=0, P=0) double;
//    (S>CW_W-1, P=1) double (invalid position). Single and double never both 1.
//  - i_correct_en=0: mask forced zero, flags and counters still reported.
//  - Double error: data passes uncorrected, o_err_double=1.
//  - Counters: +1 on output handshake with err_single (CE) / err_double (UE); stick at
//    2**CNT_W-1. i_cnt_clr wins over same-cycle increment (result 0).
//  - Async reset mid-stream: pipeline empties immediately; in-flight words lost; o_ready=1
//    first cycle after deassertion.
// TESTING
//  1 Clean encoded word, data 64'h0123_4567_89AB_CDEF, i_ready=1 -> same data 2 cycles later,
//    S=0, flags 0, counters unchanged.
//  2 Flip each codeword bit 0..71 in turn -> original data, err_single=1, S=bit index,
//    CE count=72 at end.
//  3 Flip bits 3 and 10 -> err_double=1, data = uncorrected payload, UE +1; with
//    i_correct_en=0 and 1-bit flip at 5 -> err_single=1, data still corrupted.
//  4 Back-to-back 100 words with random i_ready (50%) -> in-order output, no loss/dup,
//    o_data stable while stalled, full throughput when i_ready=1.
//  5 CNT_W=4: 20 single errors -> o_ce_cnt=15; i_cnt_clr coincident with error -> 0.
//  6 Assert i_rst_n=0 with 2 words in flight -> o_valid=0 async, counters 0, no stale output.

Source files
------------

// File: rtl/secded_correct_pipe.sv
// Two-stage SECDED (extended Hamming) decode/correct pipeline with valid/ready flow
// control and saturating corrected/uncorrectable error counters.
module secded_correct_pipe #(
   parameter  int unsigned DATA_W = 64,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned HAM_W  = ((2**3)  >= (DATA_W + 4))  ? 3  :
                                    ((2**4)  >= (DATA_W + 5))  ? 4  :
                                    ((2**5)  >= (DATA_W + 6))  ? 5  :
                                    ((2**6)  >= (DATA_W + 7))  ? 6  :
                                    ((2**7)  >= (DATA_W + 8))  ? 7  :
                                    ((2**8)  >= (DATA_W + 9))  ? 8  :
                                    ((2**9)  >= (DATA_W + 10)) ? 9  :
                                    ((2**10) >= (DATA_W + 11)) ? 10 :
                                    ((2**11) >= (DATA_W + 12)) ? 11 : 12,
   localparam int unsigned CW_W   = DATA_W + HAM_W + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [CW_W-1:0]   i_codeword,
   input  logic              i_correct_en,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [HAM_W-1:0]  o_syndrome,
   output logic              o_err_single,
   output logic              o_err_double,
   input  logic              i_cnt_clr,
   output logic [CNT_W-1:0]  o_ce_cnt,
   output logic [CNT_W-1:0]  o_ue_cnt
);

   localparam logic [HAM_W-1:0] MAX_POS = HAM_W'(CW_W - 1);

   logic              s1_valid;
   logic [CW_W-1:0]   s1_cw;
   logic              s1_cen;
   logic [HAM_W-1:0]  s1_syn;
   logic              s1_par;

   logic              s2_adv;
   logic [HAM_W-1:0]  syn_c;
   logic              par_c;
   logic [CW_W-1:0]   mask_c;
   logic [CW_W-1:0]   fixed_c;
   logic [DATA_W-1:0] data_c;
   logic              single_c;
   logic              double_c;

   assign s2_adv  = !o_valid || i_ready;
   assign o_ready = !s1_valid || s2_adv;

   always_comb begin
      syn_c = '0;
      for (int unsigned k = 1; k < CW_W; k++) begin
         if (i_codeword[k]) syn_c = syn_c ^ HAM_W'(k);
      end
      par_c = ^i_codeword;
   end

   // Syndrome beyond the last codeword position with odd parity cannot be a single flip.
   always_comb begin
      single_c = 1'b0;
      double_c = 1'b0;
      if (s1_syn == '0)                     single_c = s1_par;
      else if (s1_par && s1_syn <= MAX_POS) single_c = 1'b1;
      else                                  double_c = 1'b1;

      mask_c = '0;
      for (int unsigned k = 0; k < CW_W; k++) begin
         mask_c[k] = single_c && s1_cen && (s1_syn == HAM_W'(k));
      end
      fixed_c = s1_cw ^ mask_c;

      // Data occupies the non-power-of-two positions, shifted in so the lowest lands at bit 0.
      data_c = '0;
      for (int unsigned k = 1; k < CW_W; k++) begin
         if ((k & (k - 1)) != 0) data_c = {fixed_c[k], data_c[DATA_W-1:1]};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_cen   <= 1'b0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (o_ready) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_cw  <= i_codeword;
            s1_cen <= i_correct_en;
            s1_syn <= syn_c;
            s1_par <= par_c;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_syndrome   <= '0;
         o_err_single <= 1'b0;
         o_err_double <= 1'b0;
      end else if (s2_adv) begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            o_data       <= data_c;
            o_syndrome   <= s1_syn;
            o_err_single <= single_c;
            o_err_double <= double_c;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ce_cnt <= '0;
         o_ue_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_ce_cnt <= '0;
         o_ue_cnt <= '0;
      end else if (o_valid && i_ready) begin
         if (o_err_single && o_ce_cnt != '1) o_ce_cnt <= o_ce_cnt + 1'b1;
         if (o_err_double && o_ue_cnt != '1) o_ue_cnt <= o_ue_cnt + 1'b1;
      end
   end

endmodule
